// File: rtl/krz_map.sv
// KRZ system-bus shared types and constants for the sysbus arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package krz_map;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } krz_arb_state_e;

    // Read data returned to a master whose transaction was aborted by timeout.
    localparam logic [31:0] KRZ_SYSBUS_ABORT_DATA = 32'hDEAD_BEEF;

    // Default number of BUSY cycles to wait for the slave before aborting.
    localparam int KRZ_SYSBUS_TIMEOUT_DEFAULT = 255;

    // Registered copy of one Wishbone request, held for a whole transaction.
    typedef struct packed {
        logic [23:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } krz_sysbus_req_t;

endpackage

// File: rtl/krz_rr_pick2.sv
// Two-way round-robin pick: grants the requester that was not served last on a tie.
// Latency: combinational.
// Backpressure: none; valid is low when nothing is requested.
module krz_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    // Single requester wins outright; on a tie the one not served last wins.
    always_comb begin
        gnt   = 1'b0;
        valid = |req;
        case (req)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/krz_sysbus_arb.sv
// Round-robin arbiter granting the sysbus Wishbone slave to master 0 (crossbar) or master 1 (debug/DMA).
// Latency: stb at cycle 0 -> sys_stb_o at 1 -> sys_ack_i at k -> master ack at k+1 -> IDLE at k+2.
// Backpressure: losing master waits with stb held; optional KRZ_SYSBUS_TIMEOUT_EN aborts a stuck slave.
module krz_sysbus_arb
    import krz_map::*;
#(
    parameter int TIMEOUT = KRZ_SYSBUS_TIMEOUT_DEFAULT
)
(
    input  logic        clk,
    input  logic        rstz,
    input  logic [23:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    input  logic [23:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic [23:0] sys_adr_o,
    output logic [31:0] sys_dat_o,
    input  logic [31:0] sys_dat_i,
    output logic        sys_we_o,
    output logic [3:0]  sys_sel_o,
    output logic        sys_stb_o,
    input  logic        sys_ack_i
`ifdef KRZ_SYSBUS_TIMEOUT_EN
    ,
    output logic        timeout_o
`endif
);

    krz_arb_state_e  state, state_nxt;
    logic            gnt;
    logic            rr_last;
    krz_sysbus_req_t req_q;
    krz_sysbus_req_t m0_req, m1_req, win_req;
    logic            pick_gnt, pick_vld;
    logic            load, fin, abort, done;
    logic [31:0]     rsp_dat;

    assign m0_req  = '{adr: m0_adr_i, dat: m0_dat_i, we: m0_we_i, sel: m0_sel_i};
    assign m1_req  = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i, sel: m1_sel_i};
    assign win_req = pick_gnt ? m1_req : m0_req;

    // The slave sees only the registered copy, so sys_* is stable for the whole transaction.
    assign sys_adr_o = req_q.adr;
    assign sys_dat_o = req_q.dat;
    assign sys_we_o  = req_q.we;
    assign sys_sel_o = req_q.sel;

    krz_rr_pick2 u_pick (
        .req   ({m1_stb_i, m0_stb_i}),
        .last  (rr_last),
        .gnt   (pick_gnt),
        .valid (pick_vld)
    );

`ifdef KRZ_SYSBUS_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]           tmo_cnt;
`endif

    assign done    = fin | abort;
`ifdef KRZ_SYSBUS_TIMEOUT_EN
    assign rsp_dat = fin ? sys_dat_i : KRZ_SYSBUS_ABORT_DATA;
`else
    assign rsp_dat = sys_dat_i;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: stb is only looked at in IDLE, so a stb still high during ACK never re-grants.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fin       = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (sys_ack_i) begin
                    fin       = 1'b1;
                    state_nxt = ACK;
                end
`ifdef KRZ_SYSBUS_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    abort     = 1'b1;
                    state_nxt = ACK;
                end
`endif
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, request copy, and response return to the owning master.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            gnt       <= 1'b0;
            rr_last   <= 1'b1;
            req_q     <= '0;
            sys_stb_o <= 1'b0;
            m0_ack_o  <= 1'b0;
            m1_ack_o  <= 1'b0;
            m0_dat_o  <= '0;
            m1_dat_o  <= '0;
        end else begin
            if (state == ACK) begin
                m0_ack_o <= 1'b0;
                m1_ack_o <= 1'b0;
            end
            if (load) begin
                gnt       <= pick_gnt;
                rr_last   <= pick_gnt;
                req_q     <= win_req;
                sys_stb_o <= 1'b1;
            end
            if (done) begin
                sys_stb_o <= 1'b0;
                if (gnt) begin
                    m1_ack_o <= 1'b1;
                    m1_dat_o <= rsp_dat;
                end else begin
                    m0_ack_o <= 1'b1;
                    m0_dat_o <= rsp_dat;
                end
            end
        end
    end

`ifdef KRZ_SYSBUS_TIMEOUT_EN
    // BUSY-cycle counter and sticky abort flag; a real ack in the hit cycle wins.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            tmo_cnt   <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (load)
                tmo_cnt <= '0;
            else if (state == BUSY)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (abort)
                timeout_o <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/krz_sysbus_arb.md
Name: krz_sysbus_arb

Overview:
Two-master arbiter placed in front of the KRZ system peripheral bus slave port.
- Master 0 is the crossbar data path; master 1 is the debug/DMA path.
- Grants the single sysbus Wishbone slave to one master at a time, using round-robin priority.
- Holds the grant until the slave's registered ACK returns, then returns that ACK and the read data to the owning master.
- Both sides are Wishbone Classic, Registered Feedback.

Parameters:
TIMEOUT, 255, number of BUSY cycles without sys_ack_i before the transaction is aborted (used only when KRZ_SYSBUS_TIMEOUT_EN is defined).

Ports:
clk  in  1  clock
rstz  in  1  asynchronous active-low reset
m0_adr_i  in  24  master 0 address
m0_dat_i  in  32  master 0 write data
m0_dat_o  out  32  master 0 read data
m0_we_i  in  1  master 0 write enable
m0_sel_i  in  4  master 0 byte select
m0_stb_i  in  1  master 0 strobe
m0_ack_o  out  1  master 0 ack
m1_adr_i, m1_dat_i, m1_dat_o, m1_we_i, m1_sel_i, m1_stb_i, m1_ack_o: same as m0_*, for master 1
sys_adr_o  out  24  to sysbus
sys_dat_o  out  32  to sysbus, write data
sys_dat_i  in  32  from sysbus, read data
sys_we_o  out  1  to sysbus
sys_sel_o  out  4  to sysbus
sys_stb_o  out  1  to sysbus
sys_ack_i  in  1  from sysbus (registered by the slave)
timeout_o  out  1  sticky abort flag (present only with KRZ_SYSBUS_TIMEOUT_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset rstz is asynchronous and active-low.
- Reset values: state=IDLE, gnt=0, rr_last=1 (so master 0 wins the first tie), sys_stb_o=0, m0_ack_o=0, m1_ack_o=0, m0_dat_o=0, m1_dat_o=0, timeout_o=0.
- States: IDLE, BUSY, ACK.
- IDLE:
  - If exactly one stb is high, grant that master.
  - If both are high, grant the master that is not rr_last.
  - Register gnt, set rr_last<=gnt, register adr/dat/we/sel from the winner, set sys_stb_o<=1, go to BUSY.
  - If no stb is high, stay in IDLE.
- BUSY:
  - sys_* outputs are driven from the registered copies and stay stable for the whole transaction.
  - On sys_ack_i: sys_stb_o<=0; m{gnt}_dat_o<=sys_dat_i (on reads; on writes it is loaded with sys_dat_i anyway); m{gnt}_ack_o<=1; go to ACK.
- ACK:
  - m{gnt}_ack_o is high for exactly this one cycle.
  - The arbiter does not sample any stb, because the master's stb is still high in this cycle.
  - Unconditionally go to IDLE next cycle.
- Latency: stb sampled at cycle 0 → sys_stb_o at cycle 1 → sys_ack_i at cycle k → master ack at k+1 → IDLE at k+2. Minimum idle-to-idle is 4 cycles.
- The non-granted master's stb is ignored until the arbiter returns to IDLE. Its ack_o stays 0 throughout.
- A master deasserting stb mid-transaction is illegal. The transaction completes anyway.
- m*_dat_o holds its value until the next ack to that master.
- sys_ack_i while in IDLE or ACK is ignored.
- Reset during BUSY forces all outputs to reset values immediately. The slave is assumed reset by the same rstz.

Optional Feature:
KRZ_SYSBUS_TIMEOUT_EN
- Defined:
  - An 8-bit (clog2(TIMEOUT+1)) counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without sys_ack_i: sys_stb_o<=0, the granted master gets m_dat_o=32'hDEAD_BEEF and a one-cycle ack, go to ACK, set timeout_o<=1 (sticky until reset).
  - If sys_ack_i and the timeout hit occur in the same cycle, sys_ack_i wins and timeout_o is not set.
  - This frees masters from a sysbus stuck in its ERROR state.
- Undefined: no counter, no timeout_o port, and BUSY waits indefinitely.

Decomposition:
- Package krz_map gains:
  - state enum krz_arb_state_e {IDLE, BUSY, ACK}
  - constant KRZ_SYSBUS_ABORT_DATA=32'hDEAD_BEEF
  - constant KRZ_SYSBUS_TIMEOUT_DEFAULT=255
- Sub-module krz_rr_pick2: combinational two-way round-robin pick (req[1:0], last → gnt, valid). Reusable by future crossbar ports.

Test Plan:
- Master 0 read at adr 24'h800100, slave acks 3 cycles after stb → m0_ack_o high for 1 cycle at k+1, m0_dat_o=slave data 32'h1234_5678, m1_ack_o stays 0.
- m0_stb_i and m1_stb_i both raised at the same cycle after reset → master 0 served first, then master 1, grants alternate 0,1,0,1 over 4 repeated requests.
- Master 1 write adr 24'h800200, dat 32'hA5, sel 4'h1 → sys_* outputs hold these values stable for every BUSY cycle. sys_stb_o drops the cycle after sys_ack_i.
- Master 0 keeps stb high through the ACK cycle → no second grant is issued. The next grant occurs only after the master re-strobes while the arbiter is in IDLE.
- KRZ_SYSBUS_TIMEOUT_EN defined, TIMEOUT=8, slave never acks → ack to the master after 8 BUSY cycles, dat 32'hDEAD_BEEF, timeout_o=1 and stays set.
- rstz pulsed low during BUSY → all outputs are 0 asynchronously. After release, the first tie grants master 0.
